comet_mem_arbiter: RTL and testbench
====================================

Name: comet_mem_arbiter

Overview:
- Two-master arbiter that shares the single-cycle test RAM (separate read and write ports) between the COMET II CPU and a host loader/debug port.
- The CPU has default ownership through a combinational pass-through. Host single-word transfers are granted when the CPU is idle, when the host has waited too long, or when the host holds the CPU halted.
- Sits between COMET_II_top and test_RAM in the bench and FPGA top. The CPU gains a cpu_stall input.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_WAIT, 4, number of denied cycles after which a pending host_req is force-granted (range 1..15).

Ports:
- mclk  in  1  clock; all state changes on the rising edge.
- init  in  1  asynchronous, active-low reset.
- cpu_re  in  1  CPU read request.
- cpu_raddr  in  AW  CPU read address.
- cpu_rdata  out  DW  read data; equals mem_rdata at all times.
- cpu_we  in  1  CPU write request.
- cpu_waddr  in  AW  CPU write address.
- cpu_wdata  in  DW  CPU write data.
- cpu_stall  out  1  1 = CPU requests in this cycle are not performed; the CPU holds them.
- host_req  in  1  host transfer request (level).
- host_we  in  1  host direction: 1 = write, 0 = read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_rdata  out  DW  host read data.
- host_ack  out  1  one-cycle completion pulse.
- host_halt  in  1  hold the CPU off the memory.
- host_halted  out  1  1 while in state HALT.
- mem_re  out  1  RAM read enable.
- mem_raddr  out  AW  RAM read address.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_re.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  AW  RAM write address.
- mem_wdata  out  DW  RAM write data.

Behaviour:
- States:
  - CPU (reset state).
  - H_ISSUE.
  - H_DONE.
  - HALT.
- Reset (init=0, asynchronous):
  - state=CPU, wait_cnt=0, host_ack=0, host_rdata=0, captured host fields=0.
  - mem_re and mem_we are forced to 0 while init=0.
- State CPU:
  - cpu_stall=0.
  - mem_* = cpu_* pass-through, combinational.
  - Grant condition: host_req AND (host_halt OR (!cpu_re AND !cpu_we) OR wait_cnt>=MAX_WAIT).
  - On grant: capture host_we, host_addr and host_wdata; next state H_ISSUE; wait_cnt<=0.
  - The CPU request in the grant cycle is performed normally.
- wait_cnt:
  - Increments, saturating at 15, each CPU-state cycle with host_req=1 and no grant.
  - Clears when host_req=0.
- State H_ISSUE:
  - cpu_stall=1.
  - mem driven from the captured host fields: read gives mem_re=1, mem_raddr=addr; write gives mem_we=1, mem_waddr=addr, mem_wdata=data.
  - The other enable is 0.
  - mem_rdata this cycle belongs to any CPU read accepted in the grant cycle; the CPU consumes it normally.
  - Next state H_DONE.
- State H_DONE:
  - cpu_stall=1, mem_re=0, mem_we=0, host_ack=1.
  - For a host read, host_rdata = mem_rdata combinationally. It is also registered and held until the next host read completes.
  - For a host write, host_rdata is unchanged.
  - Next state HALT if host_halt=1, else CPU.
  - host_req is ignored in H_DONE. The host must deassert host_req or present the next transfer after seeing ack.
- State HALT:
  - cpu_stall=1, host_halted=1, mem enables 0.
  - If host_req, capture the host fields and go to H_ISSUE.
  - Else if !host_halt, go to CPU.
  - Otherwise stay in HALT.
- Throughput:
  - Unhalted host transfer: 2 stalled CPU cycles.
  - Halted back-to-back transfers: 3 cycles per word (ISSUE, DONE, HALT).
- Simultaneous events:
  - CPU read and write in the same cycle are both passed through.
  - host_halt asserted in CPU state with no host_req: go to HALT at the next edge. The CPU request in that cycle is still performed.
- Reset mid-transfer: the transfer is abandoned and no ack is produced. A write is lost only if the reset lands before the H_ISSUE edge.
- Address/data widths pass through unmodified; no wrap logic.

Test Plan:
- Reset: hold init=0 with cpu_we=1 -> mem_we=0, host_ack=0, host_rdata=0000h. Release init -> a CPU write of 1234h to 0040h appears on mem_w* in the same cycle.
- Idle grant: CPU idle, host write 00AAh to 0010h -> H_ISSUE shows mem_we=1, mem_waddr=0010h. host_ack pulses next cycle; cpu_stall is high for exactly 2 cycles.
- Starvation: CPU reads every cycle, host_req held with MAX_WAIT=4 -> grant after 4 denied cycles. The CPU read accepted in the grant cycle returns correct data during H_ISSUE.
- Host read: preload 0010h=BEEFh, host read 0010h -> host_rdata=BEEFh in the ack cycle, and it stays BEEFh after ack.
- Halt burst: host_halt=1, host writes 0001h..0003h to 0020h..0022h -> host_halted=1 between words, 3 cycles per word, cpu_stall=1 throughout. Drop halt -> CPU resumes the next cycle.
- Async reset asserted during H_ISSUE -> immediately state CPU, cpu_stall=0, and no host_ack is produced.

Source files
------------

// File: rtl/comet_mem_arbiter_if.sv
// Bus bundle between the COMET II CPU, the host loader/debug port and the test RAM.
// master = CPU/host/RAM side, slave = the arbiter.
interface comet_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_re;
  logic [AW-1:0] cpu_raddr;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_we;
  logic [AW-1:0] cpu_waddr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ack;
  logic          host_halt;
  logic          host_halted;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Handshake: host_req is a level held with stable fields until host_ack
  // pulses for one cycle; cpu_stall=1 means the CPU holds its request.
  modport master (
    output cpu_re, cpu_raddr, cpu_we, cpu_waddr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata, host_halt, mem_rdata,
    input  cpu_rdata, cpu_stall, host_rdata, host_ack, host_halted,
    input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  cpu_re, cpu_raddr, cpu_we, cpu_waddr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata, host_halt, mem_rdata,
    output cpu_rdata, cpu_stall, host_rdata, host_ack, host_halted,
    output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/comet_mem_arbiter.sv
// Shares the single-cycle test RAM between the CPU (default owner, combinational
// pass-through) and single-word host transfers; the host can also halt the CPU.
module comet_mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic               mclk,
  input  logic               init,
  comet_mem_arbiter_if.slave bus,
  output logic [1:0]         dbg_state
);
  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_H_ISSUE = 2'd1,
    ST_H_DONE  = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          h_we_q, h_we_d;
  logic [AW-1:0] h_addr_q, h_addr_d;
  logic [DW-1:0] h_wdata_q, h_wdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          grant, capture, mem_re_c, mem_we_c;

  always_ff @(posedge mclk or negedge init) begin
    if (!init) begin
      state_q      <= ST_CPU;
      wait_cnt_q   <= '0;
      h_we_q       <= 1'b0;
      h_addr_q     <= '0;
      h_wdata_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      h_we_q       <= h_we_d;
      h_addr_q     <= h_addr_d;
      h_wdata_q    <= h_wdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    host_rdata_d     = host_rdata_q;
    capture          = 1'b0;
    mem_re_c         = 1'b0;
    mem_we_c         = 1'b0;
    bus.mem_raddr    = h_addr_q;
    bus.mem_waddr    = h_addr_q;
    bus.mem_wdata    = h_wdata_q;
    bus.cpu_stall    = 1'b1;
    bus.host_ack     = 1'b0;
    bus.host_halted  = 1'b0;
    bus.host_rdata   = host_rdata_q;
    grant = bus.host_req &&
            (bus.host_halt || (!bus.cpu_re && !bus.cpu_we) || wait_cnt_q >= WAIT_LIM);

    case (state_q)
      ST_CPU: begin
        bus.cpu_stall = 1'b0;
        mem_re_c      = bus.cpu_re;
        mem_we_c      = bus.cpu_we;
        bus.mem_raddr = bus.cpu_raddr;
        bus.mem_waddr = bus.cpu_waddr;
        bus.mem_wdata = bus.cpu_wdata;
        if (grant) begin
          capture = 1'b1;
          state_d = ST_H_ISSUE;
        end else if (bus.host_req) begin
          if (wait_cnt_q != 4'hF) wait_cnt_d = wait_cnt_q + 4'd1;
        end else if (bus.host_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_H_ISSUE: begin
        mem_re_c = !h_we_q;
        mem_we_c = h_we_q;
        state_d  = ST_H_DONE;
      end
      ST_H_DONE: begin
        bus.host_ack = 1'b1;
        // Read data arrives now; forward it and keep it for the host.
        if (!h_we_q) begin
          bus.host_rdata = bus.mem_rdata;
          host_rdata_d   = bus.mem_rdata;
        end
        state_d = bus.host_halt ? ST_HALT : ST_CPU;
      end
      ST_HALT: begin
        bus.host_halted = 1'b1;
        if (bus.host_req) begin
          capture = 1'b1;
          state_d = ST_H_ISSUE;
        end else if (!bus.host_halt) begin
          state_d = ST_CPU;
        end
      end
      default: state_d = ST_CPU;
    endcase

    if (!bus.host_req || capture) wait_cnt_d = '0;
    h_we_d    = capture ? bus.host_we    : h_we_q;
    h_addr_d  = capture ? bus.host_addr  : h_addr_q;
    h_wdata_d = capture ? bus.host_wdata : h_wdata_q;
  end

  // Enables are gated by reset directly so nothing reaches the RAM while init=0.
  assign bus.mem_re    = init & mem_re_c;
  assign bus.mem_we    = init & mem_we_c;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_comet_mem_arbiter.sv
// Randomized and directed checks of comet_mem_arbiter against an ownership
// schedule model and a golden memory image.
module tb_comet_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MAX_WAIT = 4;

  logic       mclk = 1'b0;
  logic       init = 1'b0;
  logic [1:0] dbg_state;

  always #5 mclk = ~mclk;

  comet_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  comet_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .mclk(mclk), .init(init), .bus(bus), .dbg_state(dbg_state)
  );

  // Test RAM: write port, read port with one cycle of latency, old data on collision.
  logic [DW-1:0] ram [0:255];
  always @(posedge mclk) begin
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_raddr[7:0]];
    if (bus.mem_we) ram[bus.mem_waddr[7:0]] <= bus.mem_wdata;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: golden memory plus an ownership schedule.
  logic [DW-1:0] gold [0:255];
  logic [DW-1:0] exp_q [$];
  int            busy;      // host-owned cycles still to come: 2=issue, 1=done
  int            denied;    // cycles a pending host request has been refused
  bit            halted;
  bit            h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic [DW-1:0] h_last;
  bit            last_ack, dut_ack;
  int            cpu_mode;  // 0 hold, 1 idle, 2 read every cycle, 3 random

  task automatic model_reset();
    busy = 0; denied = 0; halted = 0; h_last = '0; last_ack = 0;
    exp_q.delete();
  endtask

  task automatic drive_cpu();
    case (cpu_mode)
      1: begin bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; end
      2: begin
        bus.cpu_re = 1'b1; bus.cpu_we = 1'b0;
        bus.cpu_raddr = AW'($urandom_range(0, 63));
      end
      3: begin
        bus.cpu_re    = 1'($urandom_range(0, 1));
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_raddr = AW'($urandom_range(0, 63));
        bus.cpu_waddr = AW'($urandom_range(0, 63));
        bus.cpu_wdata = DW'($urandom);
      end
      default: ;
    endcase
  endtask

  // One clock cycle: starts just after a rising edge, checks at the falling edge.
  task automatic step();
    bit stall_e, ack_e;
    logic [DW-1:0] hr_e;
    stall_e = (busy > 0) || halted;
    ack_e   = (busy == 1);
    if (!stall_e) drive_cpu();
    #1;
    @(negedge mclk);
    check("cpu_stall", 32'(bus.cpu_stall), 32'(stall_e));
    check("host_ack", 32'(bus.host_ack), 32'(ack_e));
    check("host_halted", 32'(bus.host_halted), 32'(halted && busy == 0));
    if (exp_q.size() > 0) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_q.pop_front()));
    if (!stall_e) begin
      check("mem_re", 32'(bus.mem_re), 32'(bus.cpu_re));
      check("mem_we", 32'(bus.mem_we), 32'(bus.cpu_we));
      check("mem_raddr", 32'(bus.mem_raddr), 32'(bus.cpu_raddr));
      check("mem_waddr", 32'(bus.mem_waddr), 32'(bus.cpu_waddr));
      check("mem_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
    end else if (busy == 2) begin
      check("h_mem_re", 32'(bus.mem_re), 32'(!h_we));
      check("h_mem_we", 32'(bus.mem_we), 32'(h_we));
      if (h_we) begin
        check("h_mem_waddr", 32'(bus.mem_waddr), 32'(h_addr));
        check("h_mem_wdata", 32'(bus.mem_wdata), 32'(h_wdata));
      end else begin
        check("h_mem_raddr", 32'(bus.mem_raddr), 32'(h_addr));
      end
    end else begin
      check("quiet_re", 32'(bus.mem_re), 32'd0);
      check("quiet_we", 32'(bus.mem_we), 32'd0);
    end
    hr_e = (ack_e && !h_we) ? gold[h_addr[7:0]] : h_last;
    check("host_rdata", 32'(bus.host_rdata), 32'(hr_e));
    dut_ack  = bus.host_ack;
    last_ack = ack_e;

    if (!stall_e) begin
      if (bus.cpu_re) exp_q.push_back(gold[bus.cpu_raddr[7:0]]);
      if (bus.cpu_we) gold[bus.cpu_waddr[7:0]] = bus.cpu_wdata;
    end else if (busy == 2 && h_we) begin
      gold[h_addr[7:0]] = h_wdata;
    end

    if (busy == 2) begin
      busy = 1;
    end else if (busy == 1) begin
      busy   = 0;
      halted = bus.host_halt;
      h_last = hr_e;
    end else if (bus.host_req && (halted || bus.host_halt ||
             (!bus.cpu_re && !bus.cpu_we) || denied >= MAX_WAIT)) begin
      busy = 2; denied = 0;
      h_we = bus.host_we; h_addr = bus.host_addr; h_wdata = bus.host_wdata;
    end else if (halted) begin
      if (!bus.host_halt) halted = 0;
    end else if (bus.host_req) begin
      denied = (denied < 15) ? denied + 1 : 15;
    end else begin
      denied = 0;
      if (bus.host_halt) halted = 1;
    end
    @(posedge mclk);
    #1;
  endtask

  task automatic host_xfer(input bit we, input int a, input int d, output int n);
    n = 0;
    bus.host_req = 1'b1; bus.host_we = we;
    bus.host_addr = AW'(a); bus.host_wdata = DW'(d);
    do begin
      step();
      n++;
    end while (!last_ack && n < 40);
    check("xfer_ack", 32'(dut_ack), 32'd1);
  endtask

  task automatic host_idle();
    bus.host_req = 1'b0;
    step();
  endtask

  int n;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0; gold[i] = '0;
    end
    bus.mem_rdata = '0;
    bus.cpu_re = 0; bus.cpu_raddr = '0; bus.cpu_we = 1'b1;
    bus.cpu_waddr = 16'h0040; bus.cpu_wdata = 16'h1234;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_halt = 0;
    model_reset();
    cpu_mode = 0;

    // Reset holds the RAM enables off even with a CPU write pending.
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_host_ack", 32'(bus.host_ack), 32'd0);
    check("rst_host_rdata", 32'(bus.host_rdata), 32'h0000);
    init = 1'b1;
    @(posedge mclk);
    #1;
    step();
    cpu_mode = 1;
    step();

    // Idle grant: 3 cycles from request to ack.
    host_xfer(1, 16'h0010, 16'h00AA, n);
    check("idle_cycles", 32'(n), 32'd3);
    host_idle();

    // CPU overwrite then host read.
    cpu_mode = 0;
    bus.cpu_we = 1; bus.cpu_re = 0; bus.cpu_waddr = 16'h0010; bus.cpu_wdata = 16'hBEEF;
    step();
    cpu_mode = 1;
    host_xfer(0, 16'h0010, 0, n);
    host_idle();
    host_idle();

    // Starvation: CPU reads every cycle, host granted after MAX_WAIT refusals.
    cpu_mode = 2;
    host_xfer(1, 16'h0030, 16'h5A5A, n);
    check("starve_cycles", 32'(n), 32'(MAX_WAIT + 3));
    host_idle();

    // Halt burst.
    cpu_mode = 3;
    bus.host_halt = 1'b1;
    host_idle();
    host_idle();
    for (int i = 0; i < 3; i++) begin
      host_xfer(1, 16'h0020 + i, i + 1, n);
      check("halt_word_cycles", 32'(n), 32'd3);
    end
    host_idle();
    bus.host_halt = 1'b0;
    host_idle();
    host_idle();
    host_idle();
    cpu_mode = 1;
    for (int i = 0; i < 3; i++) begin
      host_xfer(0, 16'h0020 + i, 0, n);
    end
    host_idle();

    // Randomized mixed traffic.
    cpu_mode = 3;
    for (int c = 0; c < 400; c++) begin
      if (!bus.host_req || last_ack) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.host_req   = 1'b1;
          bus.host_we    = 1'($urandom_range(0, 1));
          bus.host_addr  = AW'($urandom_range(0, 63));
          bus.host_wdata = DW'($urandom);
        end else begin
          bus.host_req = 1'b0;
        end
      end
      step();
    end
    bus.host_req = 1'b0;
    while (busy != 0) step();
    step();

    // Reset landing in the issue cycle of a host read.
    cpu_mode = 1;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0030;
    n = 0;
    while (busy != 2 && n < 10) begin
      step();
      n++;
    end
    #1;
    @(negedge mclk);
    check("pre_rst_issue_re", 32'(bus.mem_re), 32'd1);
    init = 1'b0;
    #1;
    check("mid_rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("mid_rst_re", 32'(bus.mem_re), 32'd0);
    check("mid_rst_ack", 32'(bus.host_ack), 32'd0);
    bus.host_req = 1'b0;
    model_reset();
    @(posedge mclk);
    @(negedge mclk);
    check("post_rst_ack", 32'(bus.host_ack), 32'd0);
    check("post_rst_rdata", 32'(bus.host_rdata), 32'h0000);
    init = 1'b1;
    @(posedge mclk);
    #1;
    cpu_mode = 3;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
